adc_capture: RTL and testbench

Front-end sampling stage that sits directly upstream of `encoder_fec` and produces its `data_in`/`req` pair. It reads a serial SPI ADC at a fixed sample rate and truncates each sample to a `message_data_t`. It then presents the message to `encoder_fec` with a req/ack handshake. Sample ticks that arrive while a capture or handshake is still in progress are dropped, and with the overrun feature enabled they are also counted.

---
 rtl/encoder_fec_pkg.sv | 25 ++
 rtl/adc_spi_shifter.sv | 75 +++++++
 rtl/adc_capture.sv | 137 +++++++++++++
 tb/tb_adc_capture.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_fec_pkg.sv
// Shared types for the encoder_fec datapath, including the adc_capture front end.
// message_data_t is the payload handed to encoder_fec; adc_capture truncates samples to it.
package encoder_fec_pkg;

  localparam int MSG_DATA_W = 8;

  typedef logic [MSG_DATA_W-1:0] message_data_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONVERT   = 2'd1,
    HANDSHAKE = 2'd2,
    RELEASE   = 2'd3
  } adc_capture_state_t;

  localparam int ADC_BITS_DEFAULT          = 12;
  localparam int ADC_SAMPLE_PERIOD_DEFAULT = 1000;
  localparam int ADC_CLK_DIV_DEFAULT       = 4;

  // Bits needed for a counter that must hold the value n (never less than 1).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// SPI master for one ADC conversion: drives cs_n/sclk, shifts miso MSB first on sclk rise.
// done pulses in the cycle that issues the final sclk falling edge.
module adc_spi_shifter
  import encoder_fec_pkg::*;
#(
  parameter int CLK_DIV  = ADC_CLK_DIV_DEFAULT,
  parameter int ADC_BITS = ADC_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                miso,
  output logic                sclk,
  output logic                cs_n,
  output logic                done,
  output logic [ADC_BITS-1:0] sample
);

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam int BIT_W = cnt_width(ADC_BITS);

  logic                r_active;
  logic                r_sclk;
  logic                r_cs_n;
  logic [DIV_W-1:0]    r_div;
  logic [BIT_W-1:0]    r_bit;
  logic [ADC_BITS-1:0] r_sample;
  logic                w_half_end;
  logic                w_last_bit;

  assign w_half_end = r_active && (r_div == DIV_W'(CLK_DIV - 1));
  assign w_last_bit = (r_bit == BIT_W'(ADC_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_sclk   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_div    <= '0;
      r_bit    <= '0;
      r_sample <= '0;
    end else if (start && !r_active) begin
      r_active <= 1'b1;
      r_cs_n   <= 1'b0;
      r_sclk   <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
    end else if (r_active) begin
      if (w_half_end) begin
        r_div <= '0;
        if (!r_sclk) begin
          r_sclk   <= 1'b1;
          r_sample <= {r_sample[ADC_BITS-2:0], miso};
        end else begin
          r_sclk <= 1'b0;
          // The final falling edge also releases chip select.
          if (w_last_bit) begin
            r_active <= 1'b0;
            r_cs_n   <= 1'b1;
          end else begin
            r_bit <= r_bit + BIT_W'(1);
          end
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  assign done   = w_half_end && r_sclk && w_last_bit;
  assign sclk   = r_sclk;
  assign cs_n   = r_cs_n;
  assign sample = r_sample;

endmodule

// File: rtl/adc_capture.sv
// Periodic SPI ADC capture feeding encoder_fec through a four-phase req/ack handshake.
// Define ADC_CAPTURE_OVERRUN_EN to add the saturating overrun_cnt port for dropped ticks.
module adc_capture
  import encoder_fec_pkg::*;
#(
  parameter int CLK_DIV       = ADC_CLK_DIV_DEFAULT,
  parameter int ADC_BITS      = ADC_BITS_DEFAULT,
  parameter int SAMPLE_PERIOD = ADC_SAMPLE_PERIOD_DEFAULT,
  parameter int MSG_W         = $bits(message_data_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             sclk,
  output logic             cs_n,
  input  logic             miso,
  output logic             req,
  input  logic             ack,
  output logic [MSG_W-1:0] data_out,
  output logic             busy
`ifdef ADC_CAPTURE_OVERRUN_EN
  ,
  output logic [15:0]      overrun_cnt
`endif
);

  localparam int TMR_W = cnt_width(SAMPLE_PERIOD - 1);

  logic [TMR_W-1:0]    r_timer;
  logic                r_tick;
  adc_capture_state_t  r_state;
  adc_capture_state_t  w_state_next;
  logic                w_start;
  logic                w_done;
  logic [ADC_BITS-1:0] w_sample;
  logic [MSG_W-1:0]    r_data;

  // Tick is registered so it lands exactly SAMPLE_PERIOD cycles after en rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_tick  <= 1'b0;
    end else if (!en) begin
      r_timer <= '0;
      r_tick  <= 1'b0;
    end else if (r_timer == TMR_W'(SAMPLE_PERIOD - 1)) begin
      r_timer <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_timer <= r_timer + TMR_W'(1);
      r_tick  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_tick) begin
          w_start      = 1'b1;
          w_state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (w_done) w_state_next = HANDSHAKE;
      end
      HANDSHAKE: begin
        if (ack) w_state_next = RELEASE;
      end
      RELEASE: begin
        if (!ack) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  adc_spi_shifter #(
    .CLK_DIV (CLK_DIV),
    .ADC_BITS(ADC_BITS)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .miso  (miso),
    .sclk  (sclk),
    .cs_n  (cs_n),
    .done  (w_done),
    .sample(w_sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_done) begin
      r_data <= w_sample[ADC_BITS-1 -: MSG_W];
    end
  end

  // Low-order conversion bits are truncated away.
  generate
    if (ADC_BITS > MSG_W) begin : g_lsb_drop
      logic w_unused_lsbs;
      assign w_unused_lsbs = ^w_sample[ADC_BITS-MSG_W-1:0];
    end
  endgenerate

  assign req      = (r_state == HANDSHAKE);
  assign busy     = (r_state != IDLE);
  assign data_out = r_data;

`ifdef ADC_CAPTURE_OVERRUN_EN
  logic [15:0] r_overrun;
  logic        w_drop;

  assign w_drop = r_tick && (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= '0;
    end else if (w_drop && (r_overrun != 16'hFFFF)) begin
      r_overrun <= r_overrun + 16'd1;
    end
  end

  assign overrun_cnt = r_overrun;
`endif

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture with a behavioural SPI ADC and a tick/handshake timeline model.
// Works with or without ADC_CAPTURE_OVERRUN_EN; overrun checks compile in only when the port exists.
module tb_adc_capture;

  localparam int ADC_BITS = 12;
  localparam int MSG_W    = 8;
  localparam int PERIOD   = 1000;
  localparam int CONV_LAT = 97;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             miso = 1'b0;
  logic             ack = 1'b0;
  logic             sclk;
  logic             cs_n;
  logic             req;
  logic             busy;
  logic [MSG_W-1:0] data_out;
`ifdef ADC_CAPTURE_OVERRUN_EN
  logic [15:0]      overrun_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [ADC_BITS-1:0] adc_word = '0;
  int  bit_idx = 0;
  int  sclk_pulses = 0;
  logic prev_cs_n = 1'b1;
  logic prev_sclk = 1'b0;

  adc_capture dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .miso    (miso),
    .req     (req),
    .ack     (ack),
    .data_out(data_out),
    .busy    (busy)
`ifdef ADC_CAPTURE_OVERRUN_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: presents the MSB on cs_n fall, next bit after each sclk fall.
  always @(posedge clk) begin
    #1;
    if (prev_cs_n && !cs_n) begin
      bit_idx     = ADC_BITS - 1;
      sclk_pulses = 0;
      miso        = adc_word[bit_idx];
    end else if (!cs_n && prev_sclk && !sclk && bit_idx > 0) begin
      bit_idx = bit_idx - 1;
      miso    = adc_word[bit_idx];
    end
    if (!cs_n && !prev_sclk && sclk) sclk_pulses++;
    prev_cs_n = cs_n;
    prev_sclk = sclk;
  end

  function automatic logic [MSG_W-1:0] exp_msg(input logic [ADC_BITS-1:0] w);
    return MSG_W'(w >> (ADC_BITS - MSG_W));
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_req(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (req) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic quick_ack(output logic req_after, output logic busy_after);
    ack = 1'b1;
    step();
    req_after = req;
    ack = 1'b0;
    step();
    busy_after = busy;
  endtask

  task automatic start_run(output int e);
    en  = 1'b0;
    ack = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    en    = 1'b1;
    e     = cyc;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en    = 1'b0;
    ack   = 1'b0;
    repeat (3) step();
    checks++;
    if ({sclk, cs_n, req, busy, data_out} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got sclk=%b cs_n=%b req=%b busy=%b data=%h, expected 0 1 0 0 00",
               sclk, cs_n, req, busy, data_out);
    end
`ifdef ADC_CAPTURE_OVERRUN_EN
    checks++;
    if (overrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt);
    end
`endif
    $display("reset: outputs sampled in reset");
  endtask

  task automatic test_basic;
    int e, at;
    logic ra, ba;
    adc_word = 12'hA5C;
    start_run(e);
    wait_req(1200, at);
    checks++;
    if (at != e + PERIOD + CONV_LAT) begin
      errors++;
      $display("FAIL basic_req_latency: got %0d expected %0d", at - e, PERIOD + CONV_LAT);
    end
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL basic_data: got %h expected a5", data_out);
    end
    checks++;
    if (sclk_pulses != ADC_BITS || cs_n !== 1'b1) begin
      errors++;
      $display("FAIL basic_sclk: got pulses=%0d cs_n=%b expected 12 and 1", sclk_pulses, cs_n);
    end
    quick_ack(ra, ba);
    checks++;
    if ({ra, ba} !== 2'b00) begin
      errors++;
      $display("FAIL basic_handshake: got req_after_ack=%b busy_after_release=%b expected 0 0", ra, ba);
    end
    $display("basic: req at +%0d data=%h pulses=%0d", at - e, data_out, sclk_pulses);
  endtask

  task automatic test_delayed_ack;
    int e, at;
    logic ra, ba;
    logic stable;
    logic [MSG_W-1:0] held;
    adc_word = 12'($urandom);
    start_run(e);
    wait_req(1200, at);
    held = data_out;
    checks++;
    if (at != e + PERIOD + CONV_LAT || held !== exp_msg(adc_word)) begin
      errors++;
      $display("FAIL delayed_first: got at=+%0d data=%h expected +%0d %h",
               at - e, held, PERIOD + CONV_LAT, exp_msg(adc_word));
    end
    stable = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (req !== 1'b1 || data_out !== held || cs_n !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL delayed_hold: got stable=%b expected 1", stable);
    end
    quick_ack(ra, ba);
    checks++;
    if ({ra, ba} !== 2'b00) begin
      errors++;
      $display("FAIL delayed_handshake: got req=%b busy=%b expected 0 0", ra, ba);
    end
`ifdef ADC_CAPTURE_OVERRUN_EN
    checks++;
    if (overrun_cnt !== 16'd1) begin
      errors++;
      $display("FAIL delayed_overrun: got %0d expected 1", overrun_cnt);
    end
`endif
    adc_word = 12'($urandom);
    wait_req(1000, at);
    checks++;
    if (at != e + 3 * PERIOD + CONV_LAT || data_out !== exp_msg(adc_word)) begin
      errors++;
      $display("FAIL delayed_next: got at=+%0d data=%h expected +%0d %h",
               at - e, data_out, 3 * PERIOD + CONV_LAT, exp_msg(adc_word));
    end
    quick_ack(ra, ba);
    $display("delayed_ack: held 1500 cycles, next req at +%0d data=%h", at - e, data_out);
  endtask

  task automatic test_four_phase;
    int e, at;
    logic ra, ba;
    logic held_off;
    adc_word = 12'($urandom);
    start_run(e);
    wait_req(1200, at);
    wait_until(e + 1100);
    ack = 1'b1;
    step();
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL four_phase_req_fall: got %b expected 0", req);
    end
    held_off = 1'b1;
    while (cyc < e + 2050) begin
      step();
      if (req !== 1'b0 || busy !== 1'b1 || cs_n !== 1'b1) held_off = 1'b0;
    end
    checks++;
    if (held_off !== 1'b1) begin
      errors++;
      $display("FAIL four_phase_holdoff: got %b expected 1", held_off);
    end
    ack = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL four_phase_idle: got busy=%b expected 0", busy);
    end
`ifdef ADC_CAPTURE_OVERRUN_EN
    checks++;
    if (overrun_cnt !== 16'd1) begin
      errors++;
      $display("FAIL four_phase_overrun: got %0d expected 1", overrun_cnt);
    end
`endif
    adc_word = 12'($urandom);
    wait_req(1200, at);
    checks++;
    if (at != e + 3 * PERIOD + CONV_LAT || data_out !== exp_msg(adc_word)) begin
      errors++;
      $display("FAIL four_phase_next: got at=+%0d data=%h expected +%0d %h",
               at - e, data_out, 3 * PERIOD + CONV_LAT, exp_msg(adc_word));
    end
    quick_ack(ra, ba);
    $display("four_phase: next req at +%0d data=%h", at - e, data_out);
  endtask

  task automatic test_en_drop;
    int e, t, at;
    logic ra, ba;
    logic quiet;
    adc_word = 12'($urandom);
    start_run(e);
    t = e + PERIOD;
    wait_until(t + 20);
    ack = 1'b1;
    wait_until(t + 25);
    ack = 1'b0;
    wait_until(t + 40);
    en = 1'b0;
    wait_req(200, at);
    checks++;
    if (at != t + CONV_LAT || data_out !== exp_msg(adc_word)) begin
      errors++;
      $display("FAIL en_drop_capture: got at=T+%0d data=%h expected T+%0d %h",
               at - t, data_out, CONV_LAT, exp_msg(adc_word));
    end
    quick_ack(ra, ba);
    quiet = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      step();
      if (cs_n !== 1'b1 || req !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL en_drop_quiet: got %b expected 1", quiet);
    end
    $display("en_drop: req at T+%0d data=%h, idle afterwards", at - t, data_out);
  endtask

  task automatic test_reset_mid_convert;
    int e, at, r;
    logic ra, ba;
    logic sclk_before;
    adc_word = 12'h800 | 12'($urandom);
    start_run(e);
    wait_req(1200, at);
    quick_ack(ra, ba);
    adc_word = 12'($urandom);
    wait_until(e + 2 * PERIOD + 46);
    sclk_before = sclk;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sclk_before !== 1'b1 || cs_n_before_ok() !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got sclk=%b expected 1", sclk_before);
    end
    checks++;
    if ({sclk, cs_n, req, busy, data_out} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_mid_async: got sclk=%b cs_n=%b req=%b busy=%b data=%h, expected 0 1 0 0 00",
               sclk, cs_n, req, busy, data_out);
    end
    step();
    rst_n = 1'b1;
    r = cyc;
    wait_req(1300, at);
    checks++;
    if (at != r + PERIOD + CONV_LAT || data_out !== exp_msg(adc_word)) begin
      errors++;
      $display("FAIL reset_mid_restart: got at=+%0d data=%h expected +%0d %h",
               at - r, data_out, PERIOD + CONV_LAT, exp_msg(adc_word));
    end
    quick_ack(ra, ba);
    $display("reset_mid_convert: restart req at +%0d data=%h", at - r, data_out);
  endtask

  // Sanity helper: reset is applied only when a capture was actually in flight.
  function automatic logic cs_n_before_ok();
    return prev_cs_n == 1'b0;
  endfunction

  task automatic test_random;
    int e, at, t_next, idle_cyc, d, h, exp_ovr, t_acc, n_ack;
    logic stable;
    logic [MSG_W-1:0] held;
    start_run(e);
    idle_cyc = e + 1;
    t_next   = e + PERIOD;
    exp_ovr  = 0;
    for (int n = 0; n < 5; n++) begin
      adc_word = 12'($urandom_range(0, 4095));
      while (t_next < idle_cyc) begin
        exp_ovr++;
        t_next += PERIOD;
      end
      t_acc = t_next;
      t_next += PERIOD;
      wait_req(3000, at);
      held = data_out;
      checks++;
      if (at != t_acc + CONV_LAT || held !== exp_msg(adc_word)) begin
        errors++;
        $display("FAIL random_capture[%0d]: got at=%0d data=%h expected %0d %h",
                 n, at, held, t_acc + CONV_LAT, exp_msg(adc_word));
      end
      d = $urandom_range(1, 1500);
      stable = 1'b1;
      repeat (d) begin
        step();
        if (req !== 1'b1 || data_out !== held) stable = 1'b0;
      end
      ack = 1'b1;
      n_ack = cyc;
      step();
      checks++;
      if (stable !== 1'b1 || req !== 1'b0 || cyc != n_ack + 1) begin
        errors++;
        $display("FAIL random_ack[%0d]: got stable=%b req=%b expected 1 0", n, stable, req);
      end
      h = $urandom_range(1, 1200);
      repeat (h) step();
      ack = 1'b0;
      idle_cyc = cyc + 1;
      step();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL random_release[%0d]: got busy=%b expected 0", n, busy);
      end
      $display("random[%0d]: word=%h req at +%0d data=%h ack_delay=%0d ack_hold=%0d",
               n, adc_word, at - e, held, d, h);
    end
    while (t_next < idle_cyc) begin
      exp_ovr++;
      t_next += PERIOD;
    end
`ifdef ADC_CAPTURE_OVERRUN_EN
    checks++;
    if (overrun_cnt !== 16'(exp_ovr)) begin
      errors++;
      $display("FAIL random_overrun: got %0d expected %0d", overrun_cnt, exp_ovr);
    end
`endif
    $display("random: expected dropped ticks=%0d", exp_ovr);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_ack();
    test_four_phase();
    test_en_drop();
    test_reset_mid_convert();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
